// File: rtl/if_stage.sv
// Instruction fetch stage: drives a single-outstanding request to instruction
// memory and feeds the IF/ID register, with a one-entry skid buffer for ID stalls.
module if_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        load_mem;
  logic        load_skid;
  logic        load_from_skid;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath load enables.
  always_comb begin
    state_next     = state;
    load_mem       = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    if (redirect) begin
      // A request still in flight must have its response swallowed in DROP.
      if ((state == WAIT || state == DROP) && !imem_rvalid) begin
        state_next = DROP;
      end else if (state == FETCH && imem_gnt) begin
        state_next = DROP;
      end else begin
        state_next = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_gnt) state_next = WAIT;
          else          state_next = FETCH;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!stall || !id_valid) begin
              load_mem   = 1'b1;
              state_next = FETCH;
            end else begin
              load_skid  = 1'b1;
              state_next = HOLD;
            end
          end else begin
            state_next = WAIT;
          end
        end
        HOLD: begin
          if (!stall) begin
            load_from_skid = 1'b1;
            state_next     = FETCH;
          end else begin
            state_next = HOLD;
          end
        end
        DROP: begin
          if (imem_rvalid) state_next = FETCH;
          else             state_next = DROP;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // PC, IF/ID register and skid buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc        <= 32'h0000_0000;
      id_valid  <= 1'b0;
      id_inst   <= NOP;
      id_pc     <= 32'h0000_0000;
      skid_inst <= 32'h0000_0000;
      skid_pc   <= 32'h0000_0000;
    end else if (redirect) begin
      pc       <= word_align(redirect_pc);
      id_valid <= 1'b0;
      id_inst  <= NOP;
    end else if (load_mem) begin
      id_valid <= 1'b1;
      id_inst  <= imem_rdata;
      id_pc    <= pc;
      pc       <= pc + 32'd4;
    end else if (load_from_skid) begin
      id_valid <= 1'b1;
      id_inst  <= skid_inst;
      id_pc    <= skid_pc;
      pc       <= pc + 32'd4;
    end else begin
      if (load_skid) begin
        skid_inst <= imem_rdata;
        skid_pc   <= pc;
      end
      if (!stall) begin
        id_valid <= 1'b0;
      end
    end
  end

  assign imem_req  = rstn && (state == FETCH);
  assign imem_addr = pc;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: an outstanding-request flag (with a discard mark), an optional
  // parked instruction, the fetch pointer and the IF/ID contents.
  bit          known = 1'b0;
  bit          m_out, m_disc, m_skid, m_idv;
  logic [31:0] m_pc, m_inst, m_idpc, m_skid_inst, m_skid_pc;

  bit mem_pend = 1'b0;
  int mem_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic rs, st, rd, input logic [31:0] rpc,
                              input logic g, rv, input logic [31:0] rdat);
    bit fetching, delivered, dropped, out_next;
    fetching = !m_out && !m_skid;
    if (!rs) begin
      m_out = 0; m_disc = 0; m_skid = 0; m_idv = 0;
      m_pc = 32'd0; m_inst = NOP; m_idpc = 32'd0;
      known = 1'b1;
    end else if (rd) begin
      out_next = (m_out && !rv) || (fetching && g);
      m_out  = out_next;
      m_disc = out_next;
      m_skid = 0;
      m_pc   = rpc & 32'hFFFF_FFFC;
      m_idv  = 0;
      m_inst = NOP;
    end else begin
      delivered = m_out && rv && !m_disc;
      dropped   = m_out && rv && m_disc;
      if (m_skid && !st) begin
        m_inst = m_skid_inst; m_idpc = m_skid_pc; m_idv = 1;
        m_pc = m_pc + 32'd4; m_skid = 0;
      end else if (delivered && (!st || !m_idv)) begin
        m_inst = rdat; m_idpc = m_pc; m_idv = 1;
        m_pc = m_pc + 32'd4; m_out = 0;
      end else if (delivered) begin
        m_skid = 1; m_skid_inst = rdat; m_skid_pc = m_pc; m_out = 0;
      end else if (!st) begin
        m_idv = 0;
      end
      if (dropped) begin
        m_out = 0; m_disc = 0;
      end
      if (fetching && g) m_out = 1;
    end
  endtask

  // One clock cycle: apply inputs just after negedge, check, advance the model.
  task automatic cycle(input logic rs, st, rd, input logic [31:0] rpc,
                       input logic g, rv, input logic [31:0] rdat);
    bit req_e;
    rstn = rs; stall = st; redirect = rd; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat;
    #1;
    req_e = rs && !m_out && !m_skid;
    if (known) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, req_e});
      if (req_e) chk("imem_addr", imem_addr, m_pc);
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_idv});
      chk("id_inst", id_inst, m_inst);
      chk("id_pc", id_pc, m_idpc);
    end
    model_update(rs, st, rd, rpc, g, rv, rdat);
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Sequential fetch.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0010_0093);
    chk("seq_idpc0", id_pc, 32'h0);
    chk("seq_inst0", id_inst, 32'h0010_0093);
    chk("seq_addr4", imem_addr, 32'h4);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0020_0113);
    chk("seq_idpc4", id_pc, 32'h4);
    chk("seq_addr8", imem_addr, 32'h8);

    // Grant backpressure at 0x8.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("bp_addr8", imem_addr, 32'h8);
    chk("bp_req", {31'd0, imem_req}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Stall with skid at 0xC.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0001);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBBBB_0002);
    chk("skid_idpc_held", id_pc, 32'h8);
    chk("skid_inst_held", id_inst, 32'hAAAA_0001);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("skid_idpc_c", id_pc, 32'hC);
    chk("skid_inst", id_inst, 32'hBBBB_0002);
    chk("skid_addr10", imem_addr, 32'h10);

    // Redirect during WAIT; late response dropped.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("drop_req0", {31'd0, imem_req}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("drop_addr100", imem_addr, 32'h100);
    chk("drop_nop", id_inst, NOP);
    chk("drop_valid0", {31'd0, id_valid}, 32'd0);

    // Redirect + stall + rvalid together.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'hCAFE_0003);
    chk("prio_addr40", imem_addr, 32'h40);
    chk("prio_req", {31'd0, imem_req}, 32'd1);
    chk("prio_nop", id_inst, NOP);

    // Reset while holding a parked instruction.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_0004);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h2222_0005);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rst_addr0", imem_addr, 32'h0);
    chk("rst_idpc0", id_pc, 32'h0);

    // PC wrap at the top of memory; stray rvalid in FETCH ignored.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h3333_0006);
    chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h4444_0007);
    chk("stray_inst", id_inst, 32'h3333_0006);
    chk("stray_addr", imem_addr, 32'h0);

    // Random traffic with a responder of 1..3 cycle latency.
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    mem_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        rs, st, rd, g, rv;
      logic [31:0] rpc, rdat;
      bit          rq;
      rs   = ($urandom_range(99) != 0);
      st   = ($urandom_range(99) < 40);
      rd   = ($urandom_range(99) < 8);
      rpc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      g    = ($urandom_range(3) != 0);
      rdat = $urandom;
      rv   = mem_pend ? (mem_cnt == 1) : ($urandom_range(4) == 0);
      rq   = rs && !m_out && !m_skid;
      if (!rs) begin
        mem_pend = 1'b0;
      end else if (mem_pend) begin
        if (mem_cnt == 1) mem_pend = 1'b0;
        else              mem_cnt--;
      end else if (rq && g) begin
        mem_pend = 1'b1;
        mem_cnt  = int'($urandom_range(3, 1));
      end
      cycle(rs, st, rd, rpc, g, rv, rdat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rstn  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port stall  in  1  ID stage cannot accept a new instruction; hold IF/ID outputs.
REQ-005 SHALL have port redirect  in  1  taken branch/jal/jalr from EX; flush and reload the PC.
REQ-006 SHALL have port redirect_pc  in  32  target PC for redirect.
REQ-007 SHALL have port imem_req  out  1  instruction fetch request.
REQ-008 SHALL have port imem_addr  out  32  fetch address, always word aligned.
REQ-009 SHALL have port imem_gnt  in  1  memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid  in  1  imem_rdata is valid this cycle.
REQ-011 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-012 SHALL have port id_valid  out  1  IF/ID register holds a live instruction.
REQ-013 SHALL have port id_inst  out  32  IF/ID instruction, which feeds the opcode, funct3 and funct7 fields of the decoder.
REQ-014 SHALL have port id_pc  out  32  PC of id_inst.

Function
REQ-015 SHALL keep a 32-bit pc register and a four-state FSM: FETCH, WAIT, HOLD, DROP.
REQ-016 FETCH: SHALL drive imem_req=1 and imem_addr=pc; on imem_gnt go to WAIT, otherwise stay in FETCH with the same address.
REQ-017 WAIT: SHALL drive imem_req=0 and wait for imem_rvalid.
REQ-018 WAIT with rvalid, when the slot is free (stall=0 or id_valid=0): SHALL load id_inst=imem_rdata, id_pc=pc, id_valid=1, set pc=pc+4, and go to FETCH.
REQ-019 WAIT with rvalid while stall=1 and id_valid=1: SHALL capture imem_rdata and pc into a one-entry skid buffer and go to HOLD.
REQ-020 HOLD: SHALL keep imem_req=0; when stall=0, SHALL move the skid contents into the IF/ID outputs, set pc=pc+4, and go to FETCH.
REQ-021 While stall=1 and id_valid=1, id_valid, id_inst and id_pc SHALL hold their values.
REQ-022 When stall=0 and the slot is not reloaded in a cycle, id_valid SHALL go to 0 on the next edge.
REQ-023 imem_rvalid outside WAIT and DROP SHALL be ignored.
REQ-024 On redirect=1 (any state), the next edge SHALL set pc = {redirect_pc[31:2],2'b00}, id_valid=0, id_inst=32'h00000013 (NOP), and discard the skid buffer.
REQ-025 On redirect, the next state SHALL be DROP if the current state is WAIT without rvalid, or FETCH with imem_gnt=1 that cycle; otherwise FETCH.
REQ-026 DROP: SHALL keep imem_req=0 and on imem_rvalid discard the data and go to FETCH; a redirect in DROP updates pc and stays in DROP.
REQ-027 redirect SHALL take priority over stall and over a simultaneous rvalid, which is discarded.
REQ-028 At most one request SHALL be outstanding.
REQ-029 Best-case throughput SHALL be one instruction per 2 cycles (gnt in the request cycle, rvalid on the next).
REQ-030 pc arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.

Reset
REQ-031 While rstn=0 at an edge: pc=0, state=FETCH, id_valid=0, id_inst=32'h00000013, id_pc=0, skid empty.
REQ-032 imem_req SHALL be 0 while rstn=0 is being sampled, and 1 with imem_addr=0 in the first cycle after release.
REQ-033 Reset mid-WAIT SHALL abandon the request; the instruction memory shares rstn, so no response survives reset.

Verification
REQ-034 Sequential fetch: gnt always 1, rvalid 1 cycle later, rdata=0x00100093,0x00200113 -> id_pc 0x0 then 0x4, id_valid pulses, imem_addr 0x0,0x4,0x8.
REQ-035 Gnt backpressure: gnt low for 3 cycles at pc=0x8 -> imem_req and imem_addr=0x8 held stable 4 cycles, no pc change.
REQ-036 Stall with skid: id_valid=1, stall=1, rvalid arrives for pc=0xC -> state HOLD, id outputs unchanged. Release stall -> id_pc=0xC, next imem_addr=0x10.
REQ-037 Redirect in WAIT: redirect=1, redirect_pc=0x103 during WAIT, rvalid 2 cycles later -> data dropped, id_inst=0x00000013, id_valid=0, next imem_addr=0x100.
REQ-038 Redirect+stall+rvalid in the same cycle: redirect_pc=0x40 -> redirect wins, rvalid data discarded, next FETCH address 0x40.
REQ-039 Reset mid-HOLD: rstn=0 for 1 cycle -> all outputs at reset values, first post-reset imem_addr=0x0.
